// File: rtl/nmr_bstrm_pkg.sv
// Shared types for the NMR bitstream scan scheduler: FSM state encoding and PHASE width.
package nmr_bstrm_pkg;

   localparam int unsigned PHASE_WIDTH = 2;
   localparam int unsigned STATE_WIDTH = 3;

   typedef enum logic [STATE_WIDTH-1:0] {
      S_IDLE      = 3'd0,
      S_LAUNCH    = 3'd1,
      S_WAIT_ACK  = 3'd2,
      S_WAIT_DONE = 3'd3,
      S_TR_WAIT   = 3'd4,
      S_FINISH    = 3'd5
   } sched_state_e;

endpackage

// File: rtl/nmr_tr_timer.sv
// Repetition-delay down-counter; expire_o is a registered "count reached zero" flag
// so the scheduler can launch on the very cycle the delay runs out.
module nmr_tr_timer #(
   parameter int unsigned TR_WIDTH = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load_i,
   input  logic                count_i,
   input  logic [TR_WIDTH-1:0] tr_cycles_i,
   output logic                expire_o
);

   logic [TR_WIDTH-1:0] cnt_q, cnt_d;
   logic                zero_q, zero_d;

   // Zero flag is precomputed one cycle ahead of the count it describes.
   always_comb begin
      cnt_d  = cnt_q;
      zero_d = zero_q;
      if (load_i) begin
         cnt_d  = tr_cycles_i;
         zero_d = (tr_cycles_i == '0);
      end else if (count_i && !zero_q) begin
         cnt_d  = cnt_q - TR_WIDTH'(1);
         zero_d = (cnt_q == TR_WIDTH'(1));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         zero_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         zero_q <= zero_d;
      end
   end

   assign expire_o = zero_q;

endmodule

// File: rtl/nmr_scan_sched.sv
// Scan scheduler: launches NUM_SCANS bitstream runs separated by TR_CYCLES idle cycles.
// Optional PHASE output (phase cycling) is built when NMR_SCAN_SCHED_PHASECYC_EN is defined.
module nmr_scan_sched
   import nmr_bstrm_pkg::*;
#(
   parameter int unsigned SCAN_WIDTH = 16,
   parameter int unsigned TR_WIDTH   = 32,
   parameter int unsigned BANK_WIDTH = 2
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  GO,
   input  logic                  ABORT,
   input  logic [SCAN_WIDTH-1:0] NUM_SCANS,
   input  logic [TR_WIDTH-1:0]   TR_CYCLES,
   input  logic [BANK_WIDTH-1:0] BANK_IN,
   output logic                  BSTRM_START,
   input  logic                  BSTRM_DONE,
   output logic [BANK_WIDTH-1:0] BANK,
   output logic [SCAN_WIDTH-1:0] SCAN_IDX,
   output logic                  BUSY,
   output logic                  SCHED_DONE,
   output logic                  ABORTED
`ifdef NMR_SCAN_SCHED_PHASECYC_EN
   ,output logic [PHASE_WIDTH-1:0] PHASE
`endif
);

   sched_state_e          state_q, state_d;
   logic                  start_q, start_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  aborted_q, aborted_d;
   logic                  abort_pend_q, abort_pend_d;
   logic [SCAN_WIDTH-1:0] idx_q, idx_d;
   logic [SCAN_WIDTH-1:0] nscan_q, nscan_d;
   logic [TR_WIDTH-1:0]   tr_q, tr_d;
   logic [BANK_WIDTH-1:0] bank_q, bank_d;
   logic [PHASE_WIDTH-1:0] phase_q, phase_d;
   logic                  tr_load_c, tr_count_c, tr_expire;
   logic                  last_scan_c;

   nmr_tr_timer #(.TR_WIDTH(TR_WIDTH)) u_tr_timer (
      .clk         (CLK),
      .rst_n       (RST_N),
      .load_i      (tr_load_c),
      .count_i     (tr_count_c),
      .tr_cycles_i (tr_q),
      .expire_o    (tr_expire)
   );

   assign last_scan_c = (idx_q == (nscan_q - SCAN_WIDTH'(1)));

   // Next-state and registered-output logic.
   always_comb begin
      state_d      = state_q;
      start_d      = 1'b0;
      done_d       = 1'b0;
      busy_d       = busy_q;
      aborted_d    = aborted_q;
      abort_pend_d = abort_pend_q;
      idx_d        = idx_q;
      nscan_d      = nscan_q;
      tr_d         = tr_q;
      bank_d       = bank_q;
      phase_d      = phase_q;
      tr_load_c    = 1'b0;
      tr_count_c   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (GO && BSTRM_DONE) begin
               nscan_d      = NUM_SCANS;
               tr_d         = TR_CYCLES;
               bank_d       = BANK_IN;
               idx_d        = '0;
               phase_d      = '0;
               busy_d       = 1'b1;
               aborted_d    = 1'b0;
               abort_pend_d = 1'b0;
               if (NUM_SCANS == '0) begin
                  state_d = S_FINISH;
               end else begin
                  state_d = S_LAUNCH;
                  start_d = 1'b1;
               end
            end
         end
         S_LAUNCH: begin
            abort_pend_d = abort_pend_q | ABORT;
            state_d      = S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            abort_pend_d = abort_pend_q | ABORT;
            if (!BSTRM_DONE) state_d = S_WAIT_DONE;
         end
         // An abort seen while a bitstream runs is remembered and honoured at its end.
         S_WAIT_DONE: begin
            abort_pend_d = abort_pend_q | ABORT;
            if (BSTRM_DONE) begin
               if (last_scan_c || ABORT || abort_pend_q) begin
                  state_d   = S_FINISH;
                  aborted_d = ABORT | abort_pend_q;
               end else begin
                  tr_load_c = 1'b1;
                  state_d   = S_TR_WAIT;
               end
            end
         end
         S_TR_WAIT: begin
            if (ABORT) begin
               state_d   = S_FINISH;
               aborted_d = 1'b1;
            end else if (tr_expire) begin
               state_d = S_LAUNCH;
               start_d = 1'b1;
               idx_d   = idx_q + SCAN_WIDTH'(1);
               phase_d = phase_q + PHASE_WIDTH'(1);
            end else begin
               tr_count_c = 1'b1;
            end
         end
         S_FINISH: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q      <= S_IDLE;
         start_q      <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         aborted_q    <= 1'b0;
         abort_pend_q <= 1'b0;
         idx_q        <= '0;
         nscan_q      <= '0;
         tr_q         <= '0;
         bank_q       <= '0;
         phase_q      <= '0;
      end else begin
         state_q      <= state_d;
         start_q      <= start_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         aborted_q    <= aborted_d;
         abort_pend_q <= abort_pend_d;
         idx_q        <= idx_d;
         nscan_q      <= nscan_d;
         tr_q         <= tr_d;
         bank_q       <= bank_d;
         phase_q      <= phase_d;
      end
   end

   assign BSTRM_START = start_q;
   assign BUSY        = busy_q;
   assign SCHED_DONE  = done_q;
   assign ABORTED     = aborted_q;
   assign SCAN_IDX    = idx_q;
   assign BANK        = bank_q;

`ifdef NMR_SCAN_SCHED_PHASECYC_EN
   assign PHASE = phase_q;
`else
   // Phase counter has no consumer in this build.
   logic unused_phase;
   assign unused_phase = ^phase_q;
`endif

endmodule

// File: tb/tb_nmr_scan_sched.sv
// Directed self-checking bench for nmr_scan_sched with a simple bitstream-controller model
// (DONE drops 2 cycles after START and stays low 20 cycles).
module tb_nmr_scan_sched;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        go = 1'b0;
   logic        abort_r = 1'b0;
   logic [15:0] num_scans = '0;
   logic [31:0] tr_cycles = '0;
   logic [1:0]  bank_in = '0;
   logic        bstrm_start;
   logic        bstrm_done;
   logic [1:0]  bank;
   logic [15:0] scan_idx;
   logic        busy;
   logic        sched_done;
   logic        aborted;
`ifdef NMR_SCAN_SCHED_PHASECYC_EN
   logic [1:0]  phase;
`endif

   int          n_chk = 0;
   int          n_pass = 0;
   int          cyc = 0;
   int          p = 0;
   logic        hold_low = 1'b0;
   logic        done_prev = 1'b1;
   int          start_cyc[$];
   int          rise_cyc[$];
   int          sd_cyc[$];
   int          phase_at_start[$];

   nmr_scan_sched dut (
      .CLK         (clk),
      .RST_N       (rst_n),
      .GO          (go),
      .ABORT       (abort_r),
      .NUM_SCANS   (num_scans),
      .TR_CYCLES   (tr_cycles),
      .BANK_IN     (bank_in),
      .BSTRM_START (bstrm_start),
      .BSTRM_DONE  (bstrm_done),
      .BANK        (bank),
      .SCAN_IDX    (scan_idx),
      .BUSY        (busy),
      .SCHED_DONE  (sched_done),
      .ABORTED     (aborted)
`ifdef NMR_SCAN_SCHED_PHASECYC_EN
      ,.PHASE      (phase)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   // Controller model: p counts cycles since START; DONE is low while p is 2..21.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)                p <= 0;
      else if (bstrm_start)      p <= 1;
      else if (p != 0 && p < 22) p <= p + 1;
      else                       p <= 0;
   end
   assign bstrm_done = !(p >= 2 && p <= 21) && !hold_low;

   always @(negedge clk) begin
      if (bstrm_start) begin
         start_cyc.push_back(cyc);
`ifdef NMR_SCAN_SCHED_PHASECYC_EN
         phase_at_start.push_back(int'(phase));
`endif
      end
      if (sched_done) sd_cyc.push_back(cyc);
      if (bstrm_done && !done_prev) rise_cyc.push_back(cyc);
      done_prev = bstrm_done;
   end

   task automatic start_run(input logic [15:0] num, input logic [31:0] tr,
                            input logic [1:0] bk, output int n);
      @(negedge clk);
      start_cyc.delete(); rise_cyc.delete(); sd_cyc.delete(); phase_at_start.delete();
      num_scans = num; tr_cycles = tr; bank_in = bk; go = 1'b1;
      n = cyc;
      @(negedge clk);
      go = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_chk++;
      if ({bstrm_start, busy, sched_done, aborted, scan_idx, bank} !== 22'd0)
         $display("FAIL reset_outputs: got %h want 0", {bstrm_start, busy, sched_done, aborted, scan_idx, bank});
      else n_pass++;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      n_chk++;
      if ({bstrm_start, busy, sched_done} !== 3'b000)
         $display("FAIL reset_release_idle: got %b want 000", {bstrm_start, busy, sched_done});
      else n_pass++;
   endtask

   task automatic test_basic();
      int n;
      start_run(16'd3, 32'd5, 2'd2, n);
      n_chk++;
      if ({bstrm_start, busy} !== 2'b11)
         $display("FAIL basic_first_start: got %b want 11", {bstrm_start, busy});
      else n_pass++;
      repeat (4) @(negedge clk);
      bank_in = 2'd1; num_scans = 16'd9; tr_cycles = 32'd1; go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      repeat (85) @(negedge clk);
      n_chk++;
      if (start_cyc.size() !== 3) $display("FAIL basic_start_count: got %0d want 3", start_cyc.size());
      else n_pass++;
      n_chk++;
      if (start_cyc[0] !== n + 1) $display("FAIL basic_start0_cycle: got %0d want %0d", start_cyc[0], n + 1);
      else n_pass++;
      n_chk++;
      if (start_cyc[1] - rise_cyc[0] !== 7) $display("FAIL basic_gap1: got %0d want 7", start_cyc[1] - rise_cyc[0]);
      else n_pass++;
      n_chk++;
      if (start_cyc[2] - rise_cyc[1] !== 7) $display("FAIL basic_gap2: got %0d want 7", start_cyc[2] - rise_cyc[1]);
      else n_pass++;
      n_chk++;
      if (sd_cyc.size() !== 1 || sd_cyc[0] !== n + 83)
         $display("FAIL basic_sched_done: got count %0d at %0d want 1 at %0d", sd_cyc.size(), sd_cyc[0], n + 83);
      else n_pass++;
      n_chk++;
      if (scan_idx !== 16'd2) $display("FAIL basic_scan_idx: got %0d want 2", scan_idx);
      else n_pass++;
      n_chk++;
      if ({busy, aborted, bank} !== 4'b0010)
         $display("FAIL basic_end_state: got %b want 0010", {busy, aborted, bank});
      else n_pass++;
   endtask

   task automatic test_go_blocked();
      int n;
      hold_low = 1'b1;
      start_run(16'd2, 32'd0, 2'd1, n);
      repeat (5) @(negedge clk);
      n_chk++;
      if (start_cyc.size() !== 0 || busy !== 1'b0)
         $display("FAIL go_blocked: got starts %0d busy %b want 0 0", start_cyc.size(), busy);
      else n_pass++;
      hold_low = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_abort_tr();
      int n;
      start_run(16'd4, 32'd100, 2'd3, n);
      repeat (159) @(negedge clk);
      abort_r = 1'b1;
      @(negedge clk);
      abort_r = 1'b0;
      repeat (5) @(negedge clk);
      n_chk++;
      if (start_cyc.size() !== 2 || start_cyc[1] !== n + 125)
         $display("FAIL abort_tr_starts: got %0d last at %0d want 2 last at %0d", start_cyc.size(), start_cyc[1], n + 125);
      else n_pass++;
      n_chk++;
      if (sd_cyc.size() !== 1 || sd_cyc[0] !== n + 162)
         $display("FAIL abort_tr_done: got count %0d at %0d want 1 at %0d", sd_cyc.size(), sd_cyc[0], n + 162);
      else n_pass++;
      n_chk++;
      if ({aborted, busy, scan_idx} !== {1'b1, 1'b0, 16'd1})
         $display("FAIL abort_tr_flags: got %b/%b/%0d want 1/0/1", aborted, busy, scan_idx);
      else n_pass++;
   endtask

   task automatic test_zero_scans();
      int n;
      start_run(16'd0, 32'd7, 2'd1, n);
      n_chk++;
      if ({busy, sched_done, aborted, scan_idx} !== {1'b1, 1'b0, 1'b0, 16'd0})
         $display("FAIL zero_accept: got %b/%b/%b/%0d want 1/0/0/0", busy, sched_done, aborted, scan_idx);
      else n_pass++;
      @(negedge clk);
      n_chk++;
      if ({sched_done, busy} !== 2'b10) $display("FAIL zero_done_pulse: got %b want 10", {sched_done, busy});
      else n_pass++;
      repeat (5) @(negedge clk);
      n_chk++;
      if (start_cyc.size() !== 0 || sd_cyc.size() !== 1)
         $display("FAIL zero_no_start: got starts %0d dones %0d want 0 1", start_cyc.size(), sd_cyc.size());
      else n_pass++;
   endtask

   task automatic test_abort_wait_done();
      int n;
      start_run(16'd3, 32'd5, 2'd0, n);
      repeat (9) @(negedge clk);
      abort_r = 1'b1;
      repeat (14) @(negedge clk);
      n_chk++;
      if (sd_cyc.size() !== 0 || busy !== 1'b1)
         $display("FAIL abort_wd_early: got dones %0d busy %b want 0 1", sd_cyc.size(), busy);
      else n_pass++;
      repeat (16) @(negedge clk);
      abort_r = 1'b0;
      n_chk++;
      if (sd_cyc.size() !== 1 || sd_cyc[0] !== n + 25)
         $display("FAIL abort_wd_done: got count %0d at %0d want 1 at %0d", sd_cyc.size(), sd_cyc[0], n + 25);
      else n_pass++;
      n_chk++;
      if (start_cyc.size() !== 1 || aborted !== 1'b1)
         $display("FAIL abort_wd_flags: got starts %0d aborted %b want 1 1", start_cyc.size(), aborted);
      else n_pass++;
   endtask

   task automatic test_reset_mid_run();
      int n;
      start_run(16'd3, 32'd5, 2'd3, n);
      repeat (9) @(negedge clk);
      n_chk++;
      if ({busy, bank} !== 3'b111) $display("FAIL rst_mid_pre: got %b want 111", {busy, bank});
      else n_pass++;
      rst_n = 1'b0;
      #1;
      n_chk++;
      if ({bstrm_start, busy, sched_done, aborted, scan_idx, bank} !== 22'd0)
         $display("FAIL rst_mid_outputs: got %h want 0", {bstrm_start, busy, sched_done, aborted, scan_idx, bank});
      else n_pass++;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      start_cyc.delete(); sd_cyc.delete();
      repeat (60) @(negedge clk);
      n_chk++;
      if (start_cyc.size() !== 0 || sd_cyc.size() !== 0 || busy !== 1'b0)
         $display("FAIL rst_mid_quiet: got starts %0d dones %0d busy %b want 0 0 0", start_cyc.size(), sd_cyc.size(), busy);
      else n_pass++;
   endtask

   task automatic test_tr_zero_six();
      int n;
`ifdef NMR_SCAN_SCHED_PHASECYC_EN
      int exp_ph[6] = '{0, 1, 2, 3, 0, 1};
`endif
      start_run(16'd6, 32'd0, 2'd1, n);
      repeat (149) @(negedge clk);
      n_chk++;
      if (start_cyc.size() !== 6) $display("FAIL tr0_start_count: got %0d want 6", start_cyc.size());
      else n_pass++;
      for (int k = 0; k < 5; k++) begin
         n_chk++;
         if (start_cyc[k+1] - rise_cyc[k] !== 2)
            $display("FAIL tr0_gap%0d: got %0d want 2", k, start_cyc[k+1] - rise_cyc[k]);
         else n_pass++;
      end
      n_chk++;
      if (sd_cyc.size() !== 1 || sd_cyc[0] !== n + 145 || scan_idx !== 16'd5)
         $display("FAIL tr0_finish: got dones %0d at %0d idx %0d want 1 at %0d idx 5", sd_cyc.size(), sd_cyc[0], scan_idx, n + 145);
      else n_pass++;
`ifdef NMR_SCAN_SCHED_PHASECYC_EN
      for (int k = 0; k < 6; k++) begin
         n_chk++;
         if (phase_at_start[k] !== exp_ph[k])
            $display("FAIL phase_at_start%0d: got %0d want %0d", k, phase_at_start[k], exp_ph[k]);
         else n_pass++;
      end
`endif
   endtask

   initial begin
      test_reset();
      test_basic();
      test_go_blocked();
      test_abort_tr();
      test_zero_scans();
      test_abort_wait_done();
      test_reset_mid_run();
      test_tr_zero_six();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/nmr_scan_sched.md
NMR_SCAN_SCHED -- requirements
Module: nmr_scan_sched

Interface
REQ-001 SHALL have parameter SCAN_WIDTH, default 16, width of the scan count and scan index.
REQ-002 SHALL have parameter TR_WIDTH, default 32, width of the repetition-delay counter in CLK cycles.
REQ-003 SHALL have parameter BANK_WIDTH, default 2, width of the SRAM program-bank select.
REQ-004 SHALL have port CLK, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port RST_N, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port GO, input, 1, run request, sampled only in IDLE.
REQ-007 SHALL have port ABORT, input, 1, level abort request.
REQ-008 SHALL have port NUM_SCANS, input, SCAN_WIDTH, number of scans; latched at GO.
REQ-009 SHALL have port TR_CYCLES, input, TR_WIDTH, inter-scan delay; latched at GO.
REQ-010 SHALL have port BANK_IN, input, BANK_WIDTH, program bank; latched at GO.
REQ-011 SHALL have port BSTRM_START, output, 1, one-cycle start pulse to the bitstream controller.
REQ-012 SHALL have port BSTRM_DONE, input, 1, controller idle flag: high when idle, low while running.
REQ-013 SHALL have port BANK, output, BANK_WIDTH, latched bank, held stable while BUSY.
REQ-014 SHALL have port SCAN_IDX, output, SCAN_WIDTH, index of the current or last scan.
REQ-015 SHALL have port BUSY, output, 1, high from GO acceptance until FINISH.
REQ-016 SHALL have port SCHED_DONE, output, 1, one-cycle pulse on completion.
REQ-017 SHALL have port ABORTED, output, 1, sticky flag set when the last run ended by ABORT; cleared at the next GO.

Function
REQ-018 SHALL implement the states IDLE, LAUNCH, WAIT_ACK, WAIT_DONE, TR_WAIT and FINISH.
REQ-019 IDLE with GO=1 and BSTRM_DONE=1: latch the configuration inputs, SCAN_IDX<=0, BUSY<=1; go to LAUNCH, or to FINISH if NUM_SCANS=0, in which case BSTRM_START is never pulsed.
REQ-020 IDLE with GO=1 and BSTRM_DONE=0: ignore GO.
REQ-021 GO sampled in cycle n SHALL give BSTRM_START=1 in cycle n+1 for exactly one cycle.
REQ-022 LAUNCH: pulse BSTRM_START, then go to WAIT_ACK.
REQ-023 WAIT_ACK: wait for BSTRM_DONE=0, then go to WAIT_DONE.
REQ-024 WAIT_DONE: on BSTRM_DONE=1 in cycle m, do the following.
- If SCAN_IDX = latched NUM_SCANS-1, or ABORT=1: go to FINISH.
- Otherwise: load the TR counter, go to TR_WAIT.
REQ-025 TR_WAIT: the next BSTRM_START SHALL occur in cycle m+TR_CYCLES+2; SCAN_IDX SHALL increment in the same cycle as that BSTRM_START; TR_CYCLES=0 gives BSTRM_START in cycle m+2.
REQ-026 FINISH: SCHED_DONE=1 for one cycle, BUSY<=0, go to IDLE; SCAN_IDX holds its value.
REQ-027 ABORT in TR_WAIT SHALL go to FINISH in the next cycle and set ABORTED.
REQ-028 ABORT in LAUNCH, WAIT_ACK or WAIT_DONE SHALL NOT truncate the running bitstream; the block finishes after the BSTRM_DONE rise and sets ABORTED.
REQ-029 GO while BUSY SHALL be ignored; configuration inputs changing while BUSY SHALL have no effect.
REQ-030 Scan index SHALL compare at full SCAN_WIDTH; NUM_SCANS = 2^SCAN_WIDTH-1 SHALL run that many scans without wrap.

Reset
REQ-031 RST_N=0 SHALL immediately force the following.
- State: IDLE.
- Outputs: BSTRM_START=0, BUSY=0, SCHED_DONE=0, ABORTED=0, SCAN_IDX=0, BANK=0, PHASE=0.
- Latched configuration and TR counter: 0.
REQ-032 Reset mid-run SHALL abandon the run with no further BSTRM_START.

Configuration
REQ-033 With macro NMR_SCAN_SCHED_PHASECYC_EN defined, the block SHALL provide output PHASE (2 bits).
- PHASE is 0 at GO.
- PHASE increments modulo 4 in the same cycle as each SCAN_IDX increment.
- PHASE is held stable from BSTRM_START until the BSTRM_DONE rise.
REQ-034 Without the macro, the PHASE port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-035 The state enum and PHASE width SHALL live in the shared package nmr_bstrm_pkg.
REQ-036 The TR delay SHALL be the sub-module nmr_tr_timer, with load, count and expire signals.

Verification
REQ-037 Bench SHALL cover the following scenarios.
- NUM_SCANS=3, TR_CYCLES=5, model DONE low 2 cycles after START for 20 cycles: 3 START pulses, each 7 cycles after the previous DONE rise; SCHED_DONE once; SCAN_IDX=2.
- NUM_SCANS=0, GO: SCHED_DONE 2 cycles later; no BSTRM_START.
- NUM_SCANS=4, TR_CYCLES=100, ABORT asserted in TR_WAIT after scan 1: FINISH the next cycle; ABORTED=1; total of 2 STARTs.
- ABORT during WAIT_DONE: no FINISH until the DONE rise; ABORTED=1.
- RST_N low during WAIT_DONE: all outputs 0 at once; no START after release.
- With PHASECYC enabled, NUM_SCANS=6: PHASE sequence 0,1,2,3,0,1 at the six STARTs.
